// File: rtl/alu_rmw_sequencer_if.sv
// Memory-bus bundle between the RMW sequencer (master) and the CPU data bus (slave).
interface alu_rmw_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_EN;
  logic              mem_wr_EN;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              rdy;

  modport master (
    output mem_addr, mem_rd_EN, mem_wr_EN, mem_wdata,
    input  mem_rdata, rdy
  );

  modport slave (
    input  mem_addr, mem_rd_EN, mem_wr_EN, mem_wdata,
    output mem_rdata, rdy
  );
endinterface

// File: rtl/alu_rmw_sequencer.sv
// 6502 read-modify-write sequencer: READ, DUMMY, optional FIX (ROR), WRITE.
// Define RMW_DUMMY_WRITE_EN for the cycle-accurate double write of the old value in DUMMY.
module alu_rmw_sequencer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic              carry_IN,
  output logic              busy,
  output logic              done,
  alu_rmw_sequencer_if.master bus,
  output logic [7:0]        alu_a_OUT,
  output logic [7:0]        alu_b_OUT,
  output logic              alu_carry_OUT,
  output logic              alu_sum_EN,
  output logic              alu_shiftRight_EN,
  output logic              alu_or_EN,
  input  logic [7:0]        alu_hold_IN,
  input  logic              alu_carry_IN,
  output logic [7:0]        result_OUT,
  output logic              carry_OUT,
  output logic              zero_OUT,
  output logic              negative_OUT,
  output logic              flag_nz_WE,
  output logic              flag_c_WE
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DUMMY, S_FIX, S_WRITE
  } state_t;

  typedef enum logic [2:0] {
    OP_ASL = 3'd0, OP_LSR = 3'd1, OP_ROL = 3'd2,
    OP_ROR = 3'd3, OP_INC = 3'd4, OP_DEC = 3'd5
  } op_t;

  state_t            state_q, state_d;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cin_q;
  logic [7:0]        operand_q;
  logic [7:0]        pass1_q;
  logic [7:0]        result_q;
  logic              c_q, z_q, n_q;
  logic              final_c;
  logic              capture_final;

  // Shifts take C from the adder carry or the bit shifted out; INC/DEC leave C alone.
  always_comb begin
    final_c = 1'b0;
    case (op_q)
      OP_ASL, OP_ROL: final_c = alu_carry_IN;
      OP_LSR, OP_ROR: final_c = operand_q[0];
      default:        final_c = 1'b0;
    endcase
  end

  assign capture_final = (state_q == S_FIX) ||
                         ((state_q == S_DUMMY) && (op_q != OP_ROR));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ASL;
      addr_q    <= '0;
      cin_q     <= 1'b0;
      operand_q <= '0;
      pass1_q   <= '0;
      result_q  <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start && (op <= 3'd5)) begin
        op_q   <= op_t'(op);
        addr_q <= addr;
        cin_q  <= carry_IN;
      end
      if ((state_q == S_READ) && bus.rdy)
        operand_q <= bus.mem_rdata;
      if (state_q == S_DUMMY)
        pass1_q <= alu_hold_IN;
      if (capture_final) begin
        result_q <= alu_hold_IN;
        z_q      <= (alu_hold_IN == '0);
        n_q      <= alu_hold_IN[7];
        c_q      <= final_c;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    done              = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_rd_EN     = 1'b0;
    bus.mem_wr_EN     = 1'b0;
    bus.mem_wdata     = '0;
    alu_a_OUT         = '0;
    alu_b_OUT         = '0;
    alu_carry_OUT     = 1'b0;
    alu_sum_EN        = 1'b0;
    alu_shiftRight_EN = 1'b0;
    alu_or_EN         = 1'b0;
    flag_nz_WE        = 1'b0;
    flag_c_WE         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (op <= 3'd5))
          state_d = S_READ;
      end

      S_READ: begin
        bus.mem_addr  = addr_q;
        bus.mem_rd_EN = 1'b1;
        if (bus.rdy)
          state_d = S_DUMMY;
      end

      S_DUMMY: begin
`ifdef RMW_DUMMY_WRITE_EN
        bus.mem_addr  = addr_q;
        bus.mem_wr_EN = 1'b1;
        bus.mem_wdata = operand_q;
`endif
        alu_a_OUT = operand_q;
        case (op_q)
          OP_ASL: begin alu_b_OUT = operand_q; alu_sum_EN = 1'b1; end
          OP_ROL: begin alu_b_OUT = operand_q; alu_carry_OUT = cin_q; alu_sum_EN = 1'b1; end
          OP_LSR, OP_ROR: alu_shiftRight_EN = 1'b1;
          OP_INC: begin alu_carry_OUT = 1'b1; alu_sum_EN = 1'b1; end
          OP_DEC: begin alu_b_OUT = 8'hFF; alu_sum_EN = 1'b1; end
          default: ;
        endcase
        state_d = (op_q == OP_ROR) ? S_FIX : S_WRITE;
      end

      // ROR: OR the old carry into bit 7 of the logical shift result.
      S_FIX: begin
        alu_a_OUT = pass1_q;
        alu_b_OUT = {cin_q, 7'b0};
        alu_or_EN = 1'b1;
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        bus.mem_addr  = addr_q;
        bus.mem_wr_EN = 1'b1;
        bus.mem_wdata = result_q;
        done          = 1'b1;
        flag_nz_WE    = 1'b1;
        flag_c_WE     = (op_q != OP_INC) && (op_q != OP_DEC);
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign result_OUT   = result_q;
  assign carry_OUT    = c_q;
  assign zero_OUT     = z_q;
  assign negative_OUT = n_q;

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Randomised self-checking bench for alu_rmw_sequencer with a behavioural ALU and RMW reference model.
module tb_alu_rmw_sequencer;
  localparam int ADDR_W = 16;
  localparam logic [2:0] ASL = 3'd0, LSR = 3'd1, ROL = 3'd2, ROR = 3'd3, INC = 3'd4, DEC = 3'd5;
  localparam int PH_IDLE = 0, PH_READ = 1, PH_DUMMY = 2, PH_FIX = 3, PH_WRITE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic              carry_IN;
  logic              busy, done;
  logic [7:0]        alu_a, alu_b, alu_hold;
  logic              alu_cout, alu_cin_drv, alu_sum, alu_sr, alu_or, alu_cout_in;
  logic [7:0]        result_OUT;
  logic              carry_OUT, zero_OUT, negative_OUT, flag_nz_WE, flag_c_WE;
  logic [7:0]        cur_value;
  logic [7:0]        junk = 8'h5A;

  int checks   = 0;
  int failures = 0;

  alu_rmw_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  alu_rmw_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .op                (op),
    .addr              (addr),
    .carry_IN          (carry_IN),
    .busy              (busy),
    .done              (done),
    .bus               (bus),
    .alu_a_OUT         (alu_a),
    .alu_b_OUT         (alu_b),
    .alu_carry_OUT     (alu_cin_drv),
    .alu_sum_EN        (alu_sum),
    .alu_shiftRight_EN (alu_sr),
    .alu_or_EN         (alu_or),
    .alu_hold_IN       (alu_hold),
    .alu_carry_IN      (alu_cout_in),
    .result_OUT        (result_OUT),
    .carry_OUT         (carry_OUT),
    .zero_OUT          (zero_OUT),
    .negative_OUT      (negative_OUT),
    .flag_nz_WE        (flag_nz_WE),
    .flag_c_WE         (flag_c_WE)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    alu_hold = 8'h00;
    alu_cout = 1'b0;
    if (alu_sum)
      {alu_cout, alu_hold} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin_drv};
    else if (alu_sr) begin
      alu_hold = alu_a >> 1;
      alu_cout = alu_a[0];
    end else if (alu_or)
      alu_hold = alu_a | alu_b;
  end
  assign alu_cout_in = alu_cout;

  // Bus slave: data is only meaningful when rdy=1; garbage otherwise.
  assign bus.mem_rdata = bus.rdy ? cur_value : junk;
  always @(negedge clk) junk <= 8'($urandom);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bus_vec();
    return {16'h0, busy, done, bus.mem_rd_EN, bus.mem_wr_EN, bus.mem_addr, bus.mem_wdata,
            alu_a, alu_b, alu_cin_drv, alu_sum, alu_sr, alu_or};
  endfunction

  function automatic logic [63:0] flag_vec();
    return {51'h0, result_OUT, carry_OUT, zero_OUT, negative_OUT, flag_nz_WE, flag_c_WE};
  endfunction

  // Reference result of one RMW instruction on a byte.
  task automatic ref_rmw(input logic [2:0] o, input logic [7:0] v, input logic ci,
                         output logic [7:0] nv, output logic c);
    int unsigned x;
    x = v;
    case (o)
      ASL: begin nv = 8'((x * 2) % 256); c = (x >= 128); end
      LSR: begin nv = 8'(x / 2); c = (x % 2 == 1); end
      ROL: begin nv = 8'((x * 2 + (ci ? 1 : 0)) % 256); c = (x >= 128); end
      ROR: begin nv = 8'(x / 2 + (ci ? 128 : 0)); c = (x % 2 == 1); end
      INC: begin nv = 8'((x + 1) % 256); c = 1'b0; end
      default: begin nv = 8'((x + 255) % 256); c = 1'b0; end
    endcase
  endtask

  function automatic logic [63:0] exp_bus(input int ph, input logic [2:0] o, input logic [15:0] a,
                                          input logic ci, input logic [7:0] v, input logic [7:0] nv);
    logic [19:0] alu;
    alu = '0;
    case (ph)
      PH_READ:  return {16'h0, 4'b1010, a, 8'h00, 20'h0};
      PH_DUMMY: begin
        case (o)
          ASL:      alu = {v, v, 1'b0, 3'b100};
          ROL:      alu = {v, v, ci, 3'b100};
          LSR, ROR: alu = {v, 8'h00, 1'b0, 3'b010};
          INC:      alu = {v, 8'h00, 1'b1, 3'b100};
          default:  alu = {v, 8'hFF, 1'b0, 3'b100};
        endcase
`ifdef RMW_DUMMY_WRITE_EN
        return {16'h0, 4'b1001, a, v, alu};
`else
        return {16'h0, 4'b1000, 16'h0, 8'h00, alu};
`endif
      end
      PH_FIX:   return {16'h0, 4'b1000, 16'h0, 8'h00, v >> 1, ci, 7'h00, 1'b0, 3'b001};
      PH_WRITE: return {16'h0, 4'b1101, a, nv, 20'h0};
      default:  return 64'h0;
    endcase
  endfunction

  // Entered and left at a negedge in IDLE. stalls = rdy-low READ cycles; noise = junk inputs while busy.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic ci,
                        input logic [7:0] v, input int stalls, input bit noise);
    logic [7:0] nv;
    logic       nc, cf, cwe;
    int         total, ph;
    ref_rmw(o, v, ci, nv, nc);
    cwe = (o != INC) && (o != DEC);
    cf  = cwe ? nc : 1'b0;
    cur_value = v;
    start = 1'b1; op = o; addr = a; carry_IN = ci;
    bus.rdy = 1'($urandom);
    total = stalls + 3 + ((o == ROR) ? 1 : 0);
    for (int cyc = 0; cyc < total; cyc++) begin
      @(negedge clk);
      if (cyc <= stalls)                          ph = PH_READ;
      else if (cyc == stalls + 1)                 ph = PH_DUMMY;
      else if ((o == ROR) && (cyc == stalls + 2)) ph = PH_FIX;
      else                                        ph = PH_WRITE;
      check($sformatf("bus op%0d cyc%0d", o, cyc), bus_vec(), exp_bus(ph, o, a, ci, v, nv));
      if (ph == PH_WRITE)
        check($sformatf("flags op%0d", o), flag_vec(), {51'h0, nv, cf, nv == 8'h00, nv[7], 1'b1, cwe});
      start    = noise ? 1'($urandom) : 1'b0;
      op       = noise ? 3'($urandom) : o;
      addr     = noise ? 16'($urandom) : a;
      carry_IN = noise ? 1'($urandom) : ci;
      bus.rdy  = (ph == PH_READ) ? (cyc >= stalls) : 1'($urandom);
    end
    @(negedge clk);
    check("idle bus", bus_vec(), 64'h0);
    check("idle flags held", flag_vec(), {51'h0, nv, cf, nv == 8'h00, nv[7], 2'b00});
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; carry_IN = 1'b0;
    bus.rdy = 1'b1; cur_value = 8'h00;
    repeat (2) @(negedge clk);
    check("reset bus", bus_vec(), 64'h0);
    check("reset flags", flag_vec(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ASL, 16'h0200, 1'b0, 8'h81, 0, 1'b0);
    run_op(ROR, 16'h0300, 1'b1, 8'h01, 0, 1'b0);
    run_op(INC, 16'h0010, 1'b1, 8'hFF, 0, 1'b0);
    run_op(DEC, 16'hFFFF, 1'b0, 8'h00, 0, 1'b0);
    run_op(LSR, 16'h8000, 1'b0, 8'h01, 0, 1'b0);
    run_op(ROL, 16'h1234, 1'b1, 8'h80, 3, 1'b0);

    // Invalid op codes in IDLE must not start anything.
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; op = (i % 2 == 0) ? 3'd6 : 3'd7; addr = 16'($urandom);
      @(negedge clk);
      check("invalid op", bus_vec(), 64'h0);
    end
    start = 1'b0;

    // Reset asserted during DUMMY: no WRITE may follow.
    start = 1'b1; op = ASL; addr = 16'h0400; carry_IN = 1'b0; cur_value = 8'h41; bus.rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset dummy", bus_vec(), exp_bus(PH_DUMMY, ASL, 16'h0400, 1'b0, 8'h41, 8'h82));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort bus", bus_vec(), 64'h0);
    check("abort flags", flag_vec(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-abort bus", bus_vec(), 64'h0);
    run_op(ASL, 16'h0200, 1'b0, 8'h81, 1, 1'b0);

    for (int n = 0; n < 40; n++)
      run_op(3'($urandom_range(0, 5)), 16'($urandom), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_rmw_sequencer.md
Name: alu_rmw_sequencer

Overview:
- Multi-cycle controller for 6502 read-modify-write memory instructions: ASL, LSR, ROL, ROR, INC and DEC on a memory operand.
- Fetches the operand over the CPU data bus and drives the combinational ALU's operand, enable and carry inputs.
- Captures the ALU's held result, performs the 6502 dummy write of the old value, then writes the new value and presents the C/Z/N updates.
- Sits between the CPU control unit, the ALU and the memory bus.

Parameters:
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request RMW; sampled only in IDLE
- op  in  3  0 ASL, 1 LSR, 2 ROL, 3 ROR, 4 INC, 5 DEC; 6–7 invalid
- addr  in  ADDR_W  operand address; latched on accept
- carry_IN  in  1  current P.C; latched on accept
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in WRITE
- mem_addr  out  ADDR_W  bus address
- mem_rd_EN  out  1  bus read strobe
- mem_wr_EN  out  1  bus write strobe
- mem_wdata  out  8  bus write data
- mem_rdata  in  8  bus read data; valid in a READ cycle with rdy=1
- rdy  in  1  6502 RDY; low stalls read cycles only
- alu_a_OUT, alu_b_OUT  out  8 each  ALU operands
- alu_carry_OUT  out  1  ALU carry-in
- alu_sum_EN, alu_shiftRight_EN, alu_or_EN  out  1 each  ALU operation enables; at most one high
- alu_hold_IN  in  8  ALU result
- alu_carry_IN  in  1  ALU carry-out
- result_OUT  out  8  final value
- carry_OUT, zero_OUT, negative_OUT  out  1 each  flag values
- flag_nz_WE  out  1  strobe: write N and Z
- flag_c_WE  out  1  strobe: write C

Behaviour:
- Reset: with rst_n=0 at a clk edge, state→IDLE and all internal registers clear. Every output is 0, including mem_addr, result_OUT and all flags.
- Outputs are Moore: decoded from state plus internal registers only.

States and transitions:
- IDLE: start=1 with op≤5 latches op, addr and carry_IN, then →READ. op 6–7 or start=0: stay in IDLE, no effect.
- READ:
  - Drives mem_addr=addr, mem_rd_EN=1.
  - rdy=0: hold the state and all outputs.
  - rdy=1: latch mem_rdata into the operand register, then →DUMMY.
- DUMMY:
  - Drives the bus per Optional Feature.
  - ALU pass 1 runs and alu_hold_IN/alu_carry_IN are captured.
  - Next state: ROR→FIX, otherwise →WRITE.
- FIX (ROR only):
  - No bus activity.
  - ALU pass 2: a=pass-1 result, b={c_in,7'b0}, or_EN=1; capture the hold value.
  - →WRITE.
- WRITE:
  - Drives mem_addr=addr, mem_wr_EN=1, mem_wdata=result.
  - done=1, flag_nz_WE=1, flag_c_WE=1 except for INC/DEC.
  - Flag outputs and result_OUT are valid this cycle and hold until the next accept.
  - →IDLE unconditionally; rdy is ignored.

ALU pass 1 (c_in = latched carry_IN):
- ASL: a=b=operand, carry=0, sum_EN.
- ROL: a=b=operand, carry=c_in, sum_EN.
- LSR, ROR: a=operand, shiftRight_EN.
- INC: a=operand, b=0x00, carry=1, sum_EN.
- DEC: a=operand, b=0xFF, carry=0, sum_EN.

ALU drive outside DUMMY/FIX: all ALU outputs are 0.

Flags:
- C: ASL/ROL take the captured alu_carry_IN; LSR/ROR take operand[0].
- N and Z are computed locally from the final result: N=result[7], Z=(result==0). ALU N/Z outputs are unused.
- INC and DEC have no carry side effects: carry_OUT is 0 and flag_c_WE=0.

Latency:
- start→done is 3 cycles, or 4 for ROR, plus one cycle per rdy-low READ cycle.

Boundary cases:
- start while busy, including the WRITE cycle: ignored. A new request is accepted on the IDLE cycle after WRITE.
- Reset mid-operation: abort the same edge. No further bus strobe; a pending WRITE never occurs.
- Wrap-around: INC 0xFF→0x00; DEC 0x00→0xFF; addr is used unmodified.

Optional Feature:
- Macro: RMW_DUMMY_WRITE_EN.
- Defined: DUMMY drives mem_addr=addr, mem_wr_EN=1, mem_wdata=operand. This is the cycle-accurate 6502 behaviour the NES needs, since mappers react to the double write.
- Undefined: DUMMY drives mem_rd_EN=0, mem_wr_EN=0, mem_addr=0, mem_wdata=0.
- Cycle count and all other behaviour are identical either way.

Test Plan:
- ASL, addr 0x0200 holding 0x81 → READ; DUMMY writes 0x81 (macro defined); WRITE writes 0x02; C=1, Z=0, N=0; done 3 cycles after start.
- ROR, carry_IN=1, operand 0x01 → FIX cycle with no strobes; write 0x80; C=1, N=1, Z=0; done at cycle 4.
- INC on 0xFF → write 0x00, Z=1, flag_c_WE=0. DEC on 0x00 → 0xFF, N=1, flag_c_WE=0. LSR 0x01 → 0x00, C=1, Z=1.
- rdy=0 for 3 cycles in READ → mem_rd_EN and addr held, done delayed by 3 cycles. rdy=0 during DUMMY/WRITE → writes still occur on schedule.
- rst_n=0 in DUMMY → next cycle all outputs 0, state IDLE, no WRITE strobe. A new start after reset completes normally.
- start with op=6 in IDLE, and start pulses while busy → no state change, no bus strobes.
- Rebuild with RMW_DUMMY_WRITE_EN undefined → ASL case shows only one mem_wr_EN pulse (0x02), same latency.
